// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic valid/ready pipeline stage register.
//
// Carries an opaque WIDTH-bit payload, the concatenation of all the fields of
// one pipeline stage, from an upstream stage to a downstream stage. There is
// one cycle of latency and no combinational path from in_* to out_*.
//
// SKID=1 keeps a two-entry buffer (main + skid). Because of this, in_ready is
// a function of registered state only and does not form a combinational
// back-pressure path. SKID=0 keeps a single entry, and in_ready then follows
// out_ready combinationally.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous, active-high reset (state EMPTY, payloads RST_VAL)
//   flush      synchronous kill of held and incoming entries
//   in_valid   upstream offers in_data
//   in_ready   this stage can accept a payload this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid payload
//   out_ready  downstream accepts this cycle
//   out_data   head payload
//   occupancy  number of entries held (0..2)
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
module pipe_stage_skid #(
  parameter int                 WIDTH   = 64,
  parameter int                 SKID    = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  parameter int                 CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_p1;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_p1;
  logic [WIDTH-1:0] skid_val;
  logic             in_fire;
  logic             out_fire;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  assign out_valid = (state_p1 != EMPTY);
  assign out_data  = main_p1;
  assign occupancy = (state_p1 == FULL) ? 2'd2 :
                     (state_p1 == ONE)  ? 2'd1 : 2'd0;

  // in_ready never looks at in_valid. With the skid buffer it comes from
  // registered state only; without it, the single entry may be refilled in
  // the same cycle that downstream drains it.
  generate
    if (SKID != 0) begin : g_ready_reg
      assign in_ready = (state_p1 != FULL);
    end else begin : g_ready_comb
      assign in_ready = (state_p1 == EMPTY) | out_ready;
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and payload-load decode. A flush suppresses every load, so a
  // payload accepted in the flush cycle is dropped while the held payload
  // registers keep their stale contents.
  always_comb begin
    state_nxt      = state_p1;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p1)
        EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            // Only reachable with a skid buffer: in the single-entry form,
            // in_fire in ONE implies out_ready and therefore out_fire.
            if (SKID != 0) begin
              load_skid = 1'b1;
              state_nxt = FULL;
            end
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage boundary: head (main) entry and control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1 <= EMPTY;
      main_p1  <= RST_VAL;
    end else begin
      state_p1 <= state_nxt;
      if (load_main_in) begin
        main_p1 <= in_data;
      end else if (load_main_skid) begin
        main_p1 <= skid_val;
      end
    end
  end

  // Stage boundary: second (skid) entry, present only with SKID=1.
  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] skid_p1;
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_p1 <= RST_VAL;
        end else if (load_skid) begin
          skid_p1 <= in_data;
        end
      end
      assign skid_val = skid_p1;
    end else begin : g_no_skid
      assign skid_val = RST_VAL;
    end
  endgenerate

  // Saturating stall counter; only rst clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generic, parametrised pipeline stage register that replaces per-field enable-driven stage registers between core pipeline stages, e.g. dmem->wb.
- Carries an opaque WIDTH-bit payload, which is the concatenation of all stage fields.
- Uses a valid/ready handshake on both sides, with synchronous flush.
- Optional two-entry skid buffer so in_ready is registered and does not form a combinational back-pressure path.
- Saturating stall counter for performance monitoring.

Parameters:
WIDTH, 64, payload width in bits (>=1)
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
RST_VAL, 0, payload value loaded into all entries on reset
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous kill; discards all held and incoming entries
in_valid  in  1  upstream has a payload
in_ready  out  1  stage can accept a payload this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  out_data holds a valid payload
out_ready  in  1  downstream accepts this cycle
out_data  out  WIDTH  head payload
occupancy  out  2  number of entries held (0..2)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=1 at posedge): state EMPTY, main/skid payload = RST_VAL, stall_cnt = 0. Outputs after reset: out_valid=0, out_data=RST_VAL, occupancy=0, stall_cnt=0. in_ready is 1 for both SKID settings.
- Priority: rst > flush > normal operation.
- Flush: state becomes EMPTY next cycle and occupancy=0. Payload registers are not cleared, so out_data keeps its last value and is don't-care while out_valid=0. A payload presented with in_fire in the flush cycle is dropped. stall_cnt is unaffected.
- Latency: 1 cycle. A payload accepted at edge N is visible on out_data, with out_valid=1, after edge N. There is no combinational in->out path.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid hold. in_ready never depends on in_valid.
- SKID=1 FSM (in_ready = registered state != FULL):
  - EMPTY: in_fire -> main<=in_data, ONE.
  - ONE:
    - in_fire & out_fire -> main<=in_data, stay ONE.
    - in_fire only -> skid<=in_data, FULL.
    - out_fire only -> EMPTY.
  - FULL: out_fire -> main<=skid, ONE. No in_fire is possible because in_ready=0.
  - FIFO order is preserved; no payload is ever dropped or duplicated except by flush.
- SKID=0: in_ready = !out_valid | out_ready (combinational).
  - in_fire -> main<=in_data, out_valid=1.
  - out_fire without in_fire -> out_valid=0.
  - occupancy is 0 or 1; the skid register is not instantiated.
- stall_cnt: increments by 1 at each edge where out_valid & !out_ready. It saturates at 2^CNT_W-1 and never wraps. It is cleared only by rst.
- Simultaneous flush with out_fire: the outgoing payload is considered consumed by downstream, and the state still becomes EMPTY.

Test Plan:
- Reset then stream: rst 1 cycle, then in_valid=1 with in_data=0x1,0x2,0x3 and out_ready=1 -> out_data=0x1,0x2,0x3 on consecutive cycles starting 1 cycle after first accept; occupancy=1 throughout; stall_cnt=0.
- Back-pressure fill (SKID=1): out_ready=0, push 0xA then 0xB -> occupancy 1 then 2, in_ready=0 after 2nd accept, out_data=0xA held, stall_cnt counts 1,2,3...; raise out_ready -> outputs 0xA then 0xB, in_ready returns to 1 one cycle after first drain.
- Flush with full skid (SKID=1, occupancy=2) plus in_valid=1 with 0xC in the flush cycle -> next cycle out_valid=0, occupancy=0, 0xC never appears; subsequent push 0xD emerges alone.
- SKID=0 combinational ready: out_valid=1, out_ready=0 -> in_ready=0; set out_ready=1 same cycle -> in_ready=1, new payload replaces head in one cycle with no bubble.
- Stall counter saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15; rst -> 0.
- Reset mid-operation: occupancy=2, assert rst -> next cycle out_valid=0, out_data=RST_VAL (set RST_VAL=0xDEAD), in_ready=1, stall_cnt=0.
